marquee_scroll_receiver: RTL

// - Receive end of the 6-digit scrolling marquee: samples the six active-low HEX digit buses, decodes each
//   7-seg pattern back to a 2-bit char code, acquires scroll phase and recovers the 3-char word.
// - Sits beside the marquee driver (board self-check) or on a second board wired to its HEX lines.
// - Lock FSM confirms each frame is the previous frame rotated one digit toward HEX5.

---
 rtl/marquee_pkg.sv | 48 ++++
 rtl/seg7_char_decode.sv | 25 ++
 rtl/marquee_scroll_receiver.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/marquee_pkg.sv
// Shared definitions for the 6-digit scrolling marquee (driver and receiver).
// - SEG_*   : active-low 7-segment patterns, index [0:6] = segments a..g
// - CHAR_*  : 2-bit character codes carried by the marquee
// - state_e : receiver lock FSM states
// - helpers : digit lookup with wrap and expected-frame construction
package marquee_pkg;

  localparam int unsigned NUM_DIGITS = 6;

  typedef logic [1:0] char_t;
  typedef logic [NUM_DIGITS-1:0][1:0] frame_t;

  localparam char_t CHAR_D     = 2'd0;
  localparam char_t CHAR_E     = 2'd1;
  localparam char_t CHAR_I     = 2'd2;
  localparam char_t CHAR_BLANK = 2'd3;

  localparam logic [0:6] SEG_D     = 7'b1000010;
  localparam logic [0:6] SEG_E     = 7'b0110000;
  localparam logic [0:6] SEG_I     = 7'b1001111;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_e;

  function automatic logic [2:0] phase_inc(logic [2:0] ph);
    return (ph == 3'd5) ? 3'd0 : ph + 3'd1;
  endfunction

  // Character at digit index idx, wrapping modulo NUM_DIGITS.
  function automatic char_t digit_at(frame_t f, int unsigned idx);
    logic [2:0] i;
    i = 3'(idx % NUM_DIGITS);
    return f[i];
  endfunction

  // Frame the driver shows for word {c2,c1,c0} with c0 at HEX index ph.
  function automatic frame_t expected_frame(logic [5:0] w, logic [2:0] ph);
    frame_t     f;
    logic [2:0] idx;
    f = {NUM_DIGITS{CHAR_BLANK}};
    for (int unsigned k = 0; k < 3; k++) begin
      idx    = 3'((32'(ph) + k) % NUM_DIGITS);
      f[idx] = w[2*k +: 2];
    end
    return f;
  endfunction

endpackage

// File: rtl/seg7_char_decode.sv
// Combinational decode of one active-low 7-segment digit back to a marquee character.
// - seg   : in  [0:6] segment vector, bit 0 = seg a, 0 = lit
// - code  : out 2-bit character code (CHAR_BLANK when invalid)
// - valid : out 1 when seg is one of the four legal patterns
module seg7_char_decode
  import marquee_pkg::*;
(
  input  logic [0:6] seg,
  output char_t      code,
  output logic       valid
);

  always_comb begin
    code  = CHAR_BLANK;
    valid = 1'b1;
    case (seg)
      SEG_D:     code = CHAR_D;
      SEG_E:     code = CHAR_E;
      SEG_I:     code = CHAR_I;
      SEG_BLANK: code = CHAR_BLANK;
      default:   valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/marquee_scroll_receiver.sv
// Receive end of the 6-digit scrolling marquee. Decodes the six HEX buses, acquires the scroll
// phase and recovers the 3-char word, confirming each frame is the previous one rotated by one.
// - clock       : in  sole clock, posedge
// - reset       : in  synchronous, active-high
// - frame_valid : in  one-cycle strobe, hex0..hex5 hold a new frame
// - hex0..hex5  : in  [0:6] active-low segment vectors
// - word        : out {c2,c1,c0}, c0 = leading char
// - phase       : out HEX index of c0, 0..5
// - locked      : out word/phase trustworthy
// - word_valid  : out pulse when locked rises or word changes while locked
// - frame_err   : out pulse on undecodable digit or mismatch while locked
// Latency frame_valid -> outputs is 2 cycles (decode register, then FSM).
module marquee_scroll_receiver
  import marquee_pkg::*;
#(
  parameter int unsigned LOCK_FRAMES = 2,
  parameter int unsigned MISS_LIMIT  = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       frame_valid,
  input  logic [0:6] hex0,
  input  logic [0:6] hex1,
  input  logic [0:6] hex2,
  input  logic [0:6] hex3,
  input  logic [0:6] hex4,
  input  logic [0:6] hex5,
  output logic [5:0] word,
  output logic [2:0] phase,
  output logic       locked,
  output logic       word_valid,
  output logic       frame_err
);

  // Counter value at which the next good/bad frame reaches the threshold.
  localparam logic [2:0] LOCK_LAST = 3'(LOCK_FRAMES - 1);
  localparam logic [2:0] MISS_LAST = 3'(MISS_LIMIT - 1);

  logic [0:6]            hex_arr [NUM_DIGITS];
  frame_t                dec_code;
  logic [NUM_DIGITS-1:0] dec_valid;

  assign hex_arr[0] = hex0;
  assign hex_arr[1] = hex1;
  assign hex_arr[2] = hex2;
  assign hex_arr[3] = hex3;
  assign hex_arr[4] = hex4;
  assign hex_arr[5] = hex5;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg7_char_decode u_dec (
      .seg   (hex_arr[g]),
      .code  (dec_code[g]),
      .valid (dec_valid[g])
    );
  end

  // Stage 1: registered decode.
  logic                  s1_valid_q;
  frame_t                codes_q;
  logic [NUM_DIGITS-1:0] dvalid_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid_q <= 1'b0;
      codes_q    <= '0;
      dvalid_q   <= '0;
    end else begin
      s1_valid_q <= frame_valid;
      if (frame_valid) begin
        codes_q  <= dec_code;
        dvalid_q <= dec_valid;
      end
    end
  end

  // Acquire: the leading char sits right after three trailing blanks; at most one candidate.
  logic       acq_ok;
  logic [5:0] acq_word;
  logic [2:0] acq_phase;

  always_comb begin
    acq_ok    = 1'b0;
    acq_word  = '0;
    acq_phase = '0;
    for (int unsigned p = 0; p < NUM_DIGITS; p++) begin
      if (digit_at(codes_q, p + 3) == CHAR_BLANK && digit_at(codes_q, p + 4) == CHAR_BLANK &&
          digit_at(codes_q, p + 5) == CHAR_BLANK && digit_at(codes_q, p) != CHAR_BLANK &&
          digit_at(codes_q, p + 2) != CHAR_BLANK) begin
        acq_ok    = 1'b1;
        acq_phase = 3'(p);
        acq_word  = {digit_at(codes_q, p + 2), digit_at(codes_q, p + 1), digit_at(codes_q, p)};
      end
    end
  end

  // Stage 2: lock FSM with registered outputs.
  state_e     state_q;
  logic [5:0] word_q;
  logic [2:0] phase_q;
  logic       locked_q;
  logic       word_valid_q;
  logic       frame_err_q;
  logic [2:0] match_cnt_q;
  logic [2:0] miss_cnt_q;

  logic [2:0] phase_nxt;
  logic       all_valid;
  logic       frame_match;

  assign phase_nxt   = phase_inc(phase_q);
  assign all_valid   = &dvalid_q;
  assign frame_match = (codes_q == expected_frame(word_q, phase_nxt));

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= HUNT;
      word_q       <= '0;
      phase_q      <= '0;
      locked_q     <= 1'b0;
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      match_cnt_q  <= '0;
      miss_cnt_q   <= '0;
    end else begin
      word_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      if (s1_valid_q) begin
        if (!all_valid) begin
          // Garbage on the bus: drop lock but keep the last word/phase visible.
          frame_err_q <= 1'b1;
          state_q     <= HUNT;
          locked_q    <= 1'b0;
          match_cnt_q <= '0;
          miss_cnt_q  <= '0;
        end else begin
          unique case (state_q)
            HUNT: begin
              if (acq_ok) begin
                state_q     <= VERIFY;
                word_q      <= acq_word;
                phase_q     <= acq_phase;
                match_cnt_q <= '0;
              end
            end
            VERIFY: begin
              if (frame_match) begin
                phase_q     <= phase_nxt;
                match_cnt_q <= (match_cnt_q == 3'd7) ? match_cnt_q : match_cnt_q + 3'd1;
                if (match_cnt_q >= LOCK_LAST) begin
                  state_q      <= LOCKED;
                  locked_q     <= 1'b1;
                  word_valid_q <= 1'b1;
                  miss_cnt_q   <= '0;
                end
              end else if (acq_ok) begin
                word_q      <= acq_word;
                phase_q     <= acq_phase;
                match_cnt_q <= '0;
              end else begin
                state_q     <= HUNT;
                match_cnt_q <= '0;
              end
            end
            LOCKED: begin
              if (frame_match) begin
                phase_q    <= phase_nxt;
                miss_cnt_q <= '0;
              end else if (acq_ok && acq_phase == phase_nxt && acq_word != word_q) begin
                // Driver changed the word without losing step: follow it.
                word_q       <= acq_word;
                phase_q      <= phase_nxt;
                word_valid_q <= 1'b1;
                miss_cnt_q   <= '0;
              end else begin
                frame_err_q <= 1'b1;
                phase_q     <= phase_nxt;
                if (miss_cnt_q >= MISS_LAST) begin
                  state_q     <= HUNT;
                  locked_q    <= 1'b0;
                  miss_cnt_q  <= '0;
                  match_cnt_q <= '0;
                end else begin
                  miss_cnt_q <= miss_cnt_q + 3'd1;
                end
              end
            end
            default: state_q <= HUNT;
          endcase
        end
      end
    end
  end

  assign word       = word_q;
  assign phase      = phase_q;
  assign locked     = locked_q;
  assign word_valid = word_valid_q;
  assign frame_err  = frame_err_q;

endmodule
